// File: rtl/mult_pkg.sv
// Shared constants and helpers for the nibble-array unsigned multiplier.
//   NIBBLE        : width of one partial-product operand slice
//   DEFAULT_WIDTH : default operand width of the top-level multiplier
//   prod_width()  : full product width for a given operand width
package mult_pkg;

    localparam int NIBBLE        = 4;
    localparam int DEFAULT_WIDTH = 16;

    // An unsigned w x w product never needs more than 2*w bits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_4x4_unsigned.sv
// 4x4 unsigned combinational multiplier; the leaf cell of the nibble array.
// Ports:
//   a_i [3:0] : unsigned multiplicand nibble
//   b_i [3:0] : unsigned multiplier nibble
//   p_o [7:0] : full 8-bit product a_i * b_i
module mult_4x4_unsigned
    import mult_pkg::*;
(
    input  logic [NIBBLE-1:0]   a_i,
    input  logic [NIBBLE-1:0]   b_i,
    output logic [2*NIBBLE-1:0] p_o
);

    // Operands are widened first so the product is computed at 8 bits.
    assign p_o = {{NIBBLE{1'b0}}, a_i} * {{NIBBLE{1'b0}}, b_i};

endmodule

// File: rtl/multiplier_16x16_unsigned.sv
// Unsigned WIDTH x WIDTH multiplier built from an array of 4x4 cells.
// The full product is presented combinationally on y and as a registered
// copy on y_q one clock later.
// Ports:
//   clk       : rising-edge clock for the output register
//   rst_n     : asynchronous, active-low reset of y_q / valid_out
//   a, b      : unsigned operands, WIDTH bits each
//   valid_in  : qualifies a/b for the registered path
//   y         : combinational product a*b, 2*WIDTH bits
//   y_q       : registered product, updated only when valid_in was high
//   valid_out : valid_in delayed by one clock
//
// Handshake: valid-only. valid_in high at a rising edge captures a*b into
// y_q and raises valid_out for the following cycle; there is no ready and
// no stall, so a new product can be accepted on every cycle. With valid_in
// low, y_q keeps its last value and valid_out drops.
module multiplier_16x16_unsigned
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          valid_in,
    output logic [prod_width(WIDTH)-1:0]  y,
    output logic [prod_width(WIDTH)-1:0]  y_q,
    output logic                          valid_out
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int PW = prod_width(WIDTH);

    // pp[i][j] = a nibble i times b nibble j
    logic [2*NIBBLE-1:0] pp [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mult_4x4_unsigned u_cell (
                .a_i (a[NIBBLE*i +: NIBBLE]),
                .b_i (b[NIBBLE*j +: NIBBLE]),
                .p_o (pp[i][j])
            );
        end
    end

    // Shifted-add tree: each partial product is zero-extended to the full
    // product width before shifting, so carries out of a nibble position
    // are never lost.
    logic [PW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = acc + ({{(PW-2*NIBBLE){1'b0}}, pp[i][j]} << (NIBBLE*(i+j)));
            end
        end
    end

    assign y = acc;

    // Output register: capture only on qualified cycles, hold otherwise.
    logic [PW-1:0] prod_q, prod_d;
    logic          valid_q, valid_d;

    always_comb begin
        prod_d  = valid_in ? acc : prod_q;
        valid_d = valid_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign y_q       = prod_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_multiplier_16x16_unsigned.sv
module tb_multiplier_16x16_unsigned;

    localparam int W  = 16;
    localparam int PW = 32;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          valid_in;
    logic [PW-1:0] y;
    logic [PW-1:0] y_q;
    logic          valid_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_y_q;

    multiplier_16x16_unsigned #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .y         (y),
        .y_q       (y_q),
        .valid_out (valid_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z);
        longint unsigned p;
        p = longint'(x) * longint'(z);
        return p[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the rising edge; the combinational
    // product is checked one unit later.
    task automatic drive(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic v);
        @(posedge clk);
        #1;
        a        = aa;
        b        = bb;
        valid_in = v;
        if (v) exp_q.push_back(model(aa, bb));
        #1;
        check("comb_y", y, model(aa, bb));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (valid_out === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid_out", {31'd0, valid_out}, '0);
                    end else begin
                        last_y_q = exp_q.pop_front();
                        check("reg_y_q", y_q, last_y_q);
                    end
                end else begin
                    check("hold_y_q", y_q, last_y_q);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        valid_in = 1'b0;
        last_y_q = '0;
        #3;
        check("reset_y_q", y_q, '0);
        check("reset_valid_out", {31'd0, valid_out}, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Exhaustive low range, random qualification
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                drive(W'(i), W'(j), 1'($urandom_range(0, 1)));
            end
        end
        drive(16'd31, 16'd31, 1'b1);
        check("31x31", y, 32'd961);

        // Extremes and carry across nibbles
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        check("max_sq", y, 32'hFFFE0001);
        drive(16'hFFFF, 16'h0000, 1'b1);
        check("max_x_zero", y, 32'h0);
        drive(16'h0001, 16'hFFFF, 1'b1);
        check("one_x_max", y, 32'h0000FFFF);
        drive(16'h1234, 16'h5678, 1'b1);
        check("carry_1234_5678", y, 32'h06260060);
        drive(16'h8000, 16'h8000, 1'b1);
        check("msb_sq", y, 32'h40000000);

        // Registered path and hold
        drive(16'd3, 16'd5, 1'b1);
        @(posedge clk);
        #1;
        check("reg_15", y_q, 32'd15);
        check("reg_valid_1", {31'd0, valid_out}, 32'd1);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("hold_15", y_q, 32'd15);
        check("hold_valid_0", {31'd0, valid_out}, 32'd0);

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y_q", y_q, '0);
        check("async_rst_valid", {31'd0, valid_out}, '0);
        check("async_rst_y", y, 32'd15);
        exp_q.delete();
        last_y_q = '0;
        // A qualified pair during reset must not be captured
        a        = 16'd7;
        b        = 16'd9;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_y_q", y_q, '0);
        check("rst_hold_valid", {31'd0, valid_out}, '0);
        check("rst_comb_y", y, 32'd63);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b1;

        // Random pairs, random qualification
        for (int k = 0; k < 10000; k++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        drive('0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
